// File: rtl/energy_threshold_detector_pkg.sv
// Shared types and helpers for the windowed-energy threshold detector.
package energy_threshold_detector_pkg;

  // Detector states; encodings are fixed so downstream debug taps can decode them.
  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StIdle   = 2'd1,
    StActive = 2'd2,
    StHold   = 2'd3
  } det_state_e;

  // A sum of 2**win_log2 unsigned dw-bit values fits exactly in dw + win_log2 bits.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned win_log2);
    return dw + win_log2;
  endfunction

endpackage

// File: rtl/sq_ring_buffer.sv
// Ring of the last 2**WIN_LOG2 squared samples; rd_old is the entry about to be overwritten.
module sq_ring_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIN_LOG2   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_old
);

  localparam int unsigned Depth = 2 ** WIN_LOG2;

  logic [DATA_WIDTH-1:0] ring_q [Depth];
  logic [WIN_LOG2-1:0]   wr_ptr_q;

  // Oldest entry sits at the write pointer, so it is read before being replaced.
  assign rd_old = ring_q[wr_ptr_q];

  // Write the new sample and advance the pointer; power-of-two depth wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        ring_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      ring_q[wr_ptr_q] <= wr_data;
      wr_ptr_q         <= wr_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/energy_threshold_detector.sv
// Sliding-window energy of squared samples with a hysteresis segment detector.
module energy_threshold_detector
  import energy_threshold_detector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WIN_LOG2     = 5,
  parameter int unsigned HOLD_SAMPLES = 64,
  localparam int unsigned ACC_WIDTH   = acc_width(DATA_WIDTH, WIN_LOG2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ACC_WIDTH-1:0]  th_high,
  input  logic [ACC_WIDTH-1:0]  th_low,
  output logic                  energy_vld,
  output logic [ACC_WIDTH-1:0]  energy,
  output logic                  active,
  output logic                  seg_start,
  output logic                  seg_end
);

  localparam int unsigned WinLen = 2 ** WIN_LOG2;
  localparam int unsigned HoldW  = (HOLD_SAMPLES < 2) ? 1 : $clog2(HOLD_SAMPLES + 1);

  localparam logic [WIN_LOG2:0] FillFull = (WIN_LOG2 + 1)'(WinLen);
  localparam logic [WIN_LOG2:0] FillLast = (WIN_LOG2 + 1)'(WinLen - 1);

  logic [DATA_WIDTH-1:0] rd_old;
  logic [ACC_WIDTH-1:0]  acc_d, acc_q;
  logic [WIN_LOG2:0]     fill_cnt_d, fill_cnt_q;
  logic                  energy_vld_d, energy_vld_q;
  det_state_e            state_d, state_q;
  logic [HoldW-1:0]      hold_cnt_d, hold_cnt_q;
  logic                  seg_start_d, seg_start_q;
  logic                  seg_end_d, seg_end_q;
  logic                  active_d, active_q;
  logic [31:0]           hold_inc;

  sq_ring_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .WIN_LOG2  (WIN_LOG2)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (in_valid),
    .wr_data(in_data),
    .rd_old (rd_old)
  );

  // Window sum update and fill tracking; the window is full once the Nth sample lands.
  always_comb begin
    acc_d        = acc_q;
    fill_cnt_d   = fill_cnt_q;
    energy_vld_d = 1'b0;
    if (in_valid) begin
      // Modular add/subtract is exact: the true sum always fits ACC_WIDTH.
      acc_d        = acc_q + ACC_WIDTH'(in_data) - ACC_WIDTH'(rd_old);
      energy_vld_d = (fill_cnt_q >= FillLast);
      if (fill_cnt_q != FillFull) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end
  end

  assign hold_inc = 32'(hold_cnt_q) + 32'd1;

  // Hysteresis FSM: one decision per valid energy value, strict compares taken literally.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    seg_start_d = 1'b0;
    seg_end_d   = 1'b0;
    if (energy_vld_q) begin
      unique case (state_q)
        StFill: state_d = StIdle;
        StIdle: begin
          if (acc_q > th_high) begin
            state_d     = StActive;
            seg_start_d = 1'b1;
          end
        end
        StActive: begin
          if (acc_q < th_low) begin
            state_d    = StHold;
            hold_cnt_d = HoldW'(1);
          end
        end
        StHold: begin
          if (acc_q > th_high) begin
            state_d    = StActive;
            hold_cnt_d = '0;
          end else if (acc_q < th_low) begin
            // >= keeps HOLD_SAMPLES=1 closing on the first below-low sample in HOLD.
            if (hold_inc >= 32'(HOLD_SAMPLES)) begin
              state_d    = StIdle;
              seg_end_d  = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = HoldW'(hold_inc);
            end
          end else begin
            hold_cnt_d = '0;
          end
        end
        default: state_d = StFill;
      endcase
    end
    active_d = (state_d == StActive) || (state_d == StHold);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      fill_cnt_q   <= '0;
      energy_vld_q <= 1'b0;
      state_q      <= StFill;
      hold_cnt_q   <= '0;
      seg_start_q  <= 1'b0;
      seg_end_q    <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_cnt_q   <= fill_cnt_d;
      energy_vld_q <= energy_vld_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      seg_start_q  <= seg_start_d;
      seg_end_q    <= seg_end_d;
      active_q     <= active_d;
    end
  end

  assign energy     = acc_q;
  assign energy_vld = energy_vld_q;
  assign active     = active_q;
  assign seg_start  = seg_start_q;
  assign seg_end    = seg_end_q;

endmodule

// File: tb/tb_energy_threshold_detector.sv
// Directed bench: N=4 window, HOLD_SAMPLES=2, th_high=1000, th_low=200.
module tb_energy_threshold_detector;

  localparam int unsigned DW  = 32;
  localparam int unsigned WL  = 2;
  localparam int unsigned HS  = 2;
  localparam int unsigned AW  = DW + WL;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [AW-1:0] th_high;
  logic [AW-1:0] th_low;
  logic          energy_vld;
  logic [AW-1:0] energy;
  logic          active;
  logic          seg_start;
  logic          seg_end;

  int n_vec;
  int n_err;

  energy_threshold_detector #(
    .DATA_WIDTH  (DW),
    .WIN_LOG2    (WL),
    .HOLD_SAMPLES(HS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .th_high   (th_high),
    .th_low    (th_low),
    .energy_vld(energy_vld),
    .energy    (energy),
    .active    (active),
    .seg_start (seg_start),
    .seg_end   (seg_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One valid sample; returns on the following falling edge with outputs settled.
  task automatic send(input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    int exp_e;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    th_high  = AW'(1000);
    th_low   = AW'(200);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    check("rst_energy", 64'(energy), 0);
    check("rst_vld", 64'(energy_vld), 0);
    check("rst_active", 64'(active), 0);
    check("rst_start", 64'(seg_start), 0);
    check("rst_end", 64'(seg_end), 0);

    // Fill: vld only after the 4th sample, energy tracks throughout.
    for (int i = 0; i < 4; i++) begin
      send(DW'(100));
      check("fill_vld", 64'(energy_vld), (i == 3) ? 64'd1 : 64'd0);
      check("fill_energy", 64'(energy), 64'(100 * (i + 1)));
      check("fill_start", 64'(seg_start), 0);
    end

    // Slide with gaps: 800 stays idle, 1200 opens the segment.
    send(DW'(500));
    check("slide1_energy", 64'(energy), 800);
    check("slide1_vld", 64'(energy_vld), 1);
    idle();
    check("slide1_start", 64'(seg_start), 0);
    check("slide1_active", 64'(active), 0);
    check("gap_vld", 64'(energy_vld), 0);
    send(DW'(500));
    check("slide2_energy", 64'(energy), 1200);
    idle();
    check("open_start", 64'(seg_start), 1);
    check("open_active", 64'(active), 1);
    check("open_energy", 64'(energy), 1200);
    idle();
    check("open_start_pulse", 64'(seg_start), 0);
    check("open_active_hold", 64'(active), 1);
    send(DW'(500));
    check("slide3_energy", 64'(energy), 1600);
    idle();
    check("gap_energy_hold", 64'(energy), 1600);
    check("slide3_active", 64'(active), 1);

    // Close: window drains 1500,1000,500,0; HOLD at 0, closes on the next 0.
    for (int i = 0; i < 4; i++) begin
      send(DW'(0));
      check("drain_energy", 64'(energy), 64'(1500 - 500 * i));
      idle();
      check("drain_end", 64'(seg_end), 0);
      check("drain_active", 64'(active), 1);
    end
    send(DW'(0));
    check("close_energy", 64'(energy), 0);
    idle();
    check("close_end", 64'(seg_end), 1);
    check("close_active", 64'(active), 0);
    check("close_start", 64'(seg_start), 0);
    idle();
    check("close_end_pulse", 64'(seg_end), 0);

    // Hysteresis band: reopen, enter HOLD, band sample clears hold count.
    send(DW'(1001));
    check("reopen_energy", 64'(energy), 1001);
    idle();
    check("reopen_start", 64'(seg_start), 1);
    repeat (3) send(DW'(0));
    send(DW'(0));
    check("hold_entry_energy", 64'(energy), 0);
    idle();
    check("hold_entry_active", 64'(active), 1);
    check("hold_entry_end", 64'(seg_end), 0);
    send(DW'(500));
    check("band_energy", 64'(energy), 500);
    idle();
    check("band_end", 64'(seg_end), 0);
    check("band_active", 64'(active), 1);
    repeat (3) send(DW'(0));
    check("band_hold_energy", 64'(energy), 500);
    send(DW'(0));
    check("band_low_energy", 64'(energy), 0);
    idle();
    check("band_cleared_end", 64'(seg_end), 0);
    check("band_cleared_active", 64'(active), 1);
    send(DW'(1200));
    check("rearm_energy", 64'(energy), 1200);
    idle();
    check("rearm_no_start", 64'(seg_start), 0);
    check("rearm_active", 64'(active), 1);

    // Wrap: back-to-back 0..11, energy = sum of last 4 samples.
    for (int k = 0; k < 12; k++) begin
      send(DW'(k));
      if (k == 0) exp_e = 1200;
      else if (k == 1) exp_e = 1201;
      else if (k == 2) exp_e = 1203;
      else exp_e = 4 * k - 6;
      check("wrap_energy", 64'(energy), 64'(exp_e));
      check("wrap_vld", 64'(energy_vld), 1);
    end
    idle();
    idle();
    check("wrap_closed_active", 64'(active), 0);

    // Reset mid-segment: everything clears at once, window refills.
    send(DW'(2000));
    check("pre_rst_energy", 64'(energy), 2030);
    idle();
    check("pre_rst_active", 64'(active), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_energy", 64'(energy), 0);
    check("mid_rst_vld", 64'(energy_vld), 0);
    check("mid_rst_active", 64'(active), 0);
    check("mid_rst_start", 64'(seg_start), 0);
    check("mid_rst_end", 64'(seg_end), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(DW'(100));
      check("refill_vld", 64'(energy_vld), (i == 3) ? 64'd1 : 64'd0);
      check("refill_energy", 64'(energy), 64'(100 * (i + 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
